// File: rtl/fip_32_seq_div.sv
// fip_32_seq_div: multi-cycle signed Q16.16 restoring divider with valid/ready handshakes
module fip_32_seq_div #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_overflow,
  output logic             o_underflow
);
  localparam int NW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(NW + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(NW);
  logic [1:0]       state_q, state_d;
  logic [NW-1:0]    num_q, num_d, quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d, res_q, res_d;
  logic [WIDTH:0]   div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag, trial;
  logic             ge, sat;
  // next-state: operand latch, one restoring step per CALC cycle, then a finalize/saturate step
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    a_ext   = {i_dividend[WIDTH-1], i_dividend};
    b_ext   = {i_divisor[WIDTH-1], i_divisor};
    a_mag   = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
    trial   = {rem_q, num_q[NW-1]};
    ge      = trial >= div_q;
    sat     = neg_q ? (quo_q[NW-1:WIDTH] != '0 || (quo_q[WIDTH-1] && quo_q[WIDTH-2:0] != '0))
                    : (quo_q[NW-1:WIDTH-1] != '0);
    if (state_q == IDLE) begin
      if (i_valid) begin
        state_d = CALC;
        num_d   = NW'(a_mag) << FRAC_BITS;
        div_d   = b_mag;
        neg_d   = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
      end
    end else if (state_q == CALC) begin
      if (div_q == '0) begin
        state_d = DONE;
        res_d   = neg_q ? NEG_MAX : POS_MAX;
        ovf_d   = 1'b0;
        unf_d   = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = DONE;
        res_d   = sat ? (neg_q ? NEG_MAX : POS_MAX) : (neg_q ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0]);
        ovf_d   = sat;
        unf_d   = 1'b0;
      end else begin
        rem_d = WIDTH'(ge ? trial - div_q : trial);
        quo_d = {quo_q[NW-2:0], ge};
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (i_ready) begin
      state_d = IDLE;
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign o_ready     = state_q == IDLE;
  assign o_valid     = state_q == DONE;
  assign o_quotient  = res_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
endmodule

// File: tb/tb_fip_32_seq_div.sv
// tb_fip_32_seq_div: vector table plus handshake/reset sequences with a result scoreboard
module tb_fip_32_seq_div;
  logic clk = 0, rst_n = 1, i_valid = 0, i_ready = 1;
  logic o_ready, o_valid, o_overflow, o_underflow;
  logic [31:0] dividend = 0, divisor = 0, o_quotient;
  typedef struct { logic [31:0] a, b, q; logic ovf, unf; int lat; } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fip_32_seq_div dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(dividend), .i_divisor(divisor), .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, q, input logic ovf, unf);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.ovf = ovf; v.unf = unf;
    v.lat = (b == 0) ? 1 : 49;
    return v;
  endfunction

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!o_valid && lat < 100);
  endtask

  task automatic check_result(input int lat);
    vec_t e;
    if (!o_valid) begin
      tests++; fails++;
      $display("FAIL timeout: no o_valid within %0d cycles", lat);
    end else if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: o_valid with no pending expectation, q=%h", o_quotient);
    end else begin
      e = sb.pop_front();
      chk($sformatf("lat %h/%h", e.a, e.b), lat, e.lat);
      chk($sformatf("q %h/%h", e.a, e.b), o_quotient, e.q);
      chk($sformatf("ovf %h/%h", e.a, e.b), o_overflow, e.ovf);
      chk($sformatf("unf %h/%h", e.a, e.b), o_underflow, e.unf);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    dividend = v.a; divisor = v.b; i_valid = 1;
    sb.push_back(v);
    @(posedge clk);
    #1 i_valid = 0;
    wait_result(lat);
    check_result(lat);
    @(posedge clk);
    #1 chk("ready_after_handshake", o_ready, 1);
  endtask

  initial begin
    int lat, seen;
    vecs.push_back(mk(32'h00020000, 32'h00020000, 32'h00010000, 0, 0));
    vecs.push_back(mk(32'h00008000, 32'h00004000, 32'h00020000, 0, 0));
    vecs.push_back(mk(32'h00000002, 32'h00000003, 32'h0000AAAA, 0, 0));
    vecs.push_back(mk(32'hFFFF0000, 32'h00008000, 32'hFFFE0000, 0, 0));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h00004000, 32'h7FFFFFFF, 1, 0));
    vecs.push_back(mk(32'h80000000, 32'h00010000, 32'h80000000, 0, 0));
    vecs.push_back(mk(32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1, 0));
    vecs.push_back(mk(32'h00010000, 32'h00000000, 32'h7FFFFFFF, 0, 1));
    vecs.push_back(mk(32'hFFFF0000, 32'h00000000, 32'h80000000, 0, 1));
    vecs.push_back(mk(32'h00000000, 32'h00000000, 32'h7FFFFFFF, 0, 1));
    vecs.push_back(mk(32'h00000000, 32'hFFFF0000, 32'h00000000, 0, 0));
    vecs.push_back(mk(32'hFFFD0000, 32'h00020000, 32'hFFFE8000, 0, 0));
    vecs.push_back(mk(32'hFFFFFFFE, 32'h00000003, 32'hFFFF5556, 0, 0));
    vecs.push_back(mk(32'h00010000, 32'h00000001, 32'h7FFFFFFF, 1, 0));
    vecs.push_back(mk(32'h80000000, 32'h00020000, 32'hC0000000, 0, 0));
    vecs.push_back(mk(32'hFFFF8000, 32'h00000001, 32'h80000000, 0, 0));
    #2 rst_n = 0;
    #20;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_q", o_quotient, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_unf", o_underflow, 0);
    @(negedge clk) rst_n = 1;
    foreach (vecs[i]) run_op(vecs[i]);
    // backpressure: result held in DONE, extra i_valid ignored
    i_ready = 0;
    @(negedge clk);
    dividend = 32'h00060000; divisor = 32'h00020000; i_valid = 1;
    sb.push_back(mk(32'h00060000, 32'h00020000, 32'h00030000, 0, 0));
    @(posedge clk);
    #1 i_valid = 0;
    wait_result(lat);
    check_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_valid = 1; dividend = $urandom; divisor = 32'h00010000;
      @(posedge clk);
      #1;
      chk("bp_valid", o_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_q", o_quotient, 32'h00030000);
    end
    // handshake with simultaneous new i_valid: not accepted until IDLE
    @(negedge clk);
    i_ready = 1; dividend = 32'h00050000; divisor = 32'h00010000; i_valid = 1;
    @(posedge clk);
    #1;
    chk("hs_valid_drop", o_valid, 0);
    chk("hs_ready_idle", o_ready, 1);
    sb.push_back(mk(32'h00050000, 32'h00010000, 32'h00050000, 0, 0));
    @(posedge clk);
    #1 i_valid = 0;
    chk("hs_accept_busy", o_ready, 0);
    wait_result(lat);
    check_result(lat);
    @(posedge clk);
    #1 chk("hs_back_idle", o_ready, 1);
    // asynchronous reset in the middle of CALC
    @(negedge clk);
    dividend = 32'h00020000; divisor = 32'h00010000; i_valid = 1;
    @(posedge clk);
    #1 i_valid = 0;
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_q", o_quotient, 0);
    chk("mid_rst_ovf", o_overflow, 0);
    chk("mid_rst_unf", o_underflow, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (o_valid) seen = 1;
    end
    chk("no_result_after_abort", seen, 0);
    run_op(mk(32'h00030000, 32'h00010000, 32'h00030000, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
